// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle for muldiv_ctrl. The master issues operations,
// the slave (the controller) returns status and the HI/LO contents.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, op1, op2,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, op1, op2,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Multiply is shift-add and divide is restoring division, both on operand
// magnitudes, one bit per cycle; signs are restored in a single fix-up cycle.
module muldiv_ctrl (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;       // {partial product | remainder, multiplier | quotient}
    logic [31:0] b_q, b_d;           // multiplicand or divisor magnitude
    logic [4:0]  count_q, count_d;   // iteration index within RUN
    logic        is_div_q, is_div_d;
    logic        neg_a_q, neg_a_d;   // op1 was negative in a signed operation
    logic        neg_b_q, neg_b_d;   // op2 was negative in a signed operation
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand magnitudes; the low op bit distinguishes unsigned forms.
    logic        op_signed, op1_neg, op2_neg;
    logic [31:0] op1_mag, op2_mag;
    assign op_signed = ~bus.op[0];
    assign op1_neg   = op_signed & bus.op1[31];
    assign op2_neg   = op_signed & bus.op2[31];
    assign op1_mag   = op1_neg ? (32'd0 - bus.op1) : bus.op1;
    assign op2_mag   = op2_neg ? (32'd0 - bus.op2) : bus.op2;

    // One shift-add step: add the multiplicand when the multiplier LSB is set,
    // keeping the carry as the new top bit of the shifted accumulator.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);

    // One restoring step: trial-subtract the divisor from the shifted remainder.
    logic [32:0] div_part, div_diff;
    assign div_part = acc_q[63:31];
    assign div_diff = div_part - {1'b0, b_q};

    // Sign fix-up: quotient/product negate on differing signs, remainder follows
    // the dividend. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_q) : acc_q;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = neg_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    // Next-state, datapath and HI/LO update for every state.
    always_comb begin
        // NOTE: every _d takes its _q value first so no path can infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {32'd0, op2_mag};
                            b_d      = op1_mag;
                            is_div_d = 1'b0;
                            neg_a_d  = op1_neg;
                            neg_b_d  = op2_neg;
                            count_d  = 5'd0;
                            dbz_d    = 1'b0;
                            state_d  = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.op2 == 32'd0) begin
                                dbz_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                acc_d    = {32'd0, op1_mag};
                                b_d      = op2_mag;
                                is_div_d = 1'b1;
                                neg_a_d  = op1_neg;
                                neg_b_d  = op2_neg;
                                count_d  = 5'd0;
                                dbz_d    = 1'b0;
                                state_d  = S_RUN;
                            end
                        end
                        OP_MTHI: hi_d = bus.op1;
                        OP_MTLO: lo_d = bus.op1;
                        default: ;  // reserved op codes are ignored
                    endcase
                end
            end
            S_RUN: begin
                count_d = count_q + 5'd1;
                if (is_div_q) begin
                    if (div_diff[32]) begin
                        acc_d = {div_part[31:0], acc_q[30:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                if (count_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                dbz_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments make every register update from the same pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: datapath registers are cleared too, so a discarded operation leaves no residue.
        if (reset) begin
            acc_q    <= 64'd0;
            b_q      <= 32'd0;
            count_q  <= 5'd0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = (state_q == S_DONE) && dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected results computed
// with plain integer arithmetic; a monitor pops and compares on every done.
module tb_muldiv_ctrl;
    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;   // value of cyc at the negedge where done must be seen
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = 32'd0;  // committed HI/LO according to the model
    logic [31:0] m_lo = 32'd0;
    exp_t        sb[$];

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
                check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
    end

    // Reference model: compute the result of a MULT/MULTU/DIV/DIVU and queue it.
    task automatic push_expect(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int c0, output int due);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        e.dbz = 1'b0;
        e.hi  = m_hi;
        e.lo  = m_lo;
        case (o)
            MULT: begin
                p = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                end else if (o == DIV) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        // done is visible one cycle after accept for a zero divisor, else 34.
        e.due = e.dbz ? c0 : c0 + 33;
        due   = e.due;
        sb.push_back(e);
    endtask

    // Drive a request now and hold it across one rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int c0);
        bus.start = 1'b1;
        bus.op    = o;
        bus.op1   = a;
        bus.op2   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t || clk) @(negedge clk);
    endtask

    // Issue one operation from a negedge and wait until its effect is visible.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int c0, due;
        @(negedge clk);
        issue(o, a, b, c0);
        if (o <= DIVU) begin
            push_expect(o, a, b, c0, due);
            wait_to(due);
        end else begin
            if (o == MTHI) m_hi = a;
            if (o == MTLO) m_lo = a;
            @(negedge clk);
            check("mt_busy", 64'(bus.busy), 64'd0);
            check("mt_done", 64'(bus.done), 64'd0);
            check("mt_hi", 64'(bus.hi), 64'(m_hi));
            check("mt_lo", 64'(bus.lo), 64'(m_lo));
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c0, due;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.op1   = 32'd0;
        bus.op2   = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);

        // First start right after reset release, with busy traced every cycle.
        reset = 1'b0;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0);
        push_expect(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0, due);
        for (int j = 0; j <= 33; j++) begin
            wait_to(c0 + j);
            check($sformatf("busy_cycle%0d", j + 1), 64'(bus.busy), 64'(j <= 32));
        end
        check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(bus.lo), 64'h0000_0001);

        // A start sampled during the done cycle is ignored.
        bus.start = 1'b1;
        bus.op    = MTHI;
        bus.op1   = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("done_cycle_start_ignored", 64'(bus.hi), 64'hFFFF_FFFE);

        // Earliest next accept: the very next edge.
        issue(MULT, 32'hFFFF_FFFD, 32'd5, c0);
        push_expect(MULT, 32'hFFFF_FFFD, 32'd5, c0, due);
        wait_to(due);
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);

        do_op(DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("ovf_hi", 64'(bus.hi), 64'h0000_0000);

        do_op(MTHI, 32'd0, 32'd0);
        do_op(MTLO, 32'h1234_5678, 32'd0);
        do_op(DIVU, 32'd100, 32'd0);
        check("dbz_lo", 64'(bus.lo), 64'h1234_5678);
        check("dbz_hi", 64'(bus.hi), 64'd0);

        // Requests while busy are ignored.
        @(negedge clk);
        issue(DIVU, 32'd100, 32'd7, c0);
        push_expect(DIVU, 32'd100, 32'd7, c0, due);
        wait_to(c0 + 4);
        issue(MTHI, 32'h0000_AAAA, 32'd0, c0);
        c0 = c0 - 5;
        @(negedge clk);
        check("busy_mthi_ignored", 64'(bus.hi), 64'(m_hi));
        check("busy_after_mthi", 64'(bus.busy), 64'd1);
        wait_to(c0 + 19);
        issue(MULT, 32'd3, 32'd3, c0);
        c0 = c0 - 20;
        @(negedge clk);
        check("busy_mult_ignored", 64'(bus.lo), 64'(m_lo));
        check("busy_after_mult", 64'(bus.busy), 64'd1);
        wait_to(due);
        check("divu_hi", 64'(bus.hi), 64'd2);
        check("divu_lo", 64'(bus.lo), 64'd14);

        // Reserved codes are no-ops.
        do_op(3'b110, 32'h5555_5555, 32'd1);
        do_op(3'b111, 32'h6666_6666, 32'd1);

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        issue(MULT, 32'h0001_2345, 32'h0000_0777, c0);
        wait_to(c0 + 9);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'd0);
        check("midrst_lo", 64'(bus.lo), 64'd0);
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        do_op(DIVU, 32'd9, 32'd3);
        check("post_rst_lo", 64'(bus.lo), 64'd3);
        check("post_rst_hi", 64'(bus.hi), 64'd0);

        // Randomised mix of all op codes against the model.
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), rand_word(), rand_word());
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
